// File: rtl/tt_pkg.sv
// Shared types and sizes for the truth-table scanner.
// Pure declarations; no timing or backpressure of its own.
package tt_pkg;
  localparam int NUM_VECTORS = 16;
  localparam int IDX_W       = 4;
  localparam int CNT_W       = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;
endpackage

// File: rtl/tt_scanner_if.sv
// Bundle between the scanner (master) and its host plus the 4-in/1-out block under test (slave).
// Level signals only; start is the sole request and is never back-pressured.
interface tt_scanner_if;
  logic                               start;
  logic [tt_pkg::NUM_VECTORS-1:0]     expected;
  logic                               a_out;
  logic                               b_out;
  logic                               c_out;
  logic                               d_out;
  logic                               z_in;
  logic                               busy;
  logic                               done;
  logic [tt_pkg::NUM_VECTORS-1:0]     truth_table;
  logic                               mismatch;
  logic [tt_pkg::IDX_W-1:0]           first_fail_idx;
  logic [tt_pkg::CNT_W-1:0]           fail_count;

  modport master (
    input  start, expected, z_in,
    output a_out, b_out, c_out, d_out, busy, done,
           truth_table, mismatch, first_fail_idx, fail_count
  );

  modport slave (
    output start, expected, z_in,
    input  a_out, b_out, c_out, d_out, busy, done,
           truth_table, mismatch, first_fail_idx, fail_count
  );
endinterface

// File: rtl/tt_settle_timer.sv
// Loadable down-counter: expired_o is high once SETTLE_CYCLES-1 decrements have elapsed since load.
// With SETTLE_CYCLES=0 it loads zero and reads expired at once; the scanner then skips SETTLE.
module tt_settle_timer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic load_i,
  input  logic dec_i,
  output logic expired_o
);
  localparam int CW = 8;
  localparam logic [CW-1:0] LOAD_VAL = (SETTLE_CYCLES > 0) ? CW'(SETTLE_CYCLES - 1) : '0;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);
endmodule

// File: rtl/tt_scanner.sv
// Walks all 16 vectors onto a..d, samples z after a settle interval and scores the truth table.
// done pulses 1+16*(SETTLE_CYCLES+1) cycles after an accepted start; start outside IDLE is dropped.
module tt_scanner
  import tt_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input logic          clk,
  input logic          rst_n,
  tt_scanner_if.master bus
);
  localparam state_e SCAN_ST = (SETTLE_CYCLES > 0) ? SETTLE : SAMPLE;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_VECTORS-1:0] exp_q, exp_d;
  logic [NUM_VECTORS-1:0] tt_q, tt_d;
  logic [CNT_W-1:0]       fcnt_q, fcnt_d;
  logic [IDX_W-1:0]       ffi_q, ffi_d;
  logic                   mism_q, mism_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [IDX_W-1:0]       vec_q, vec_d;
  logic                   tmr_clr, tmr_load, tmr_dec, tmr_expired;

  tt_settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (tmr_clr),
    .load_i    (tmr_load),
    .dec_i     (tmr_dec),
    .expired_o (tmr_expired)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    exp_d    = exp_q;
    tt_d     = tt_q;
    fcnt_d   = fcnt_q;
    ffi_d    = ffi_q;
    mism_d   = mism_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    tmr_clr  = 1'b0;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          exp_d    = bus.expected;
          tt_d     = '0;
          mism_d   = 1'b0;
          fcnt_d   = '0;
          ffi_d    = '0;
          idx_d    = '0;
          busy_d   = 1'b1;
          tmr_load = 1'b1;
          state_d  = SCAN_ST;
        end
      end
      SETTLE: begin
        if (tmr_expired) begin
          state_d = SAMPLE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      SAMPLE: begin
        tt_d[idx_q] = bus.z_in;
        if (bus.z_in != exp_q[idx_q]) begin
          fcnt_d = fcnt_q + 1'b1;
          // fail_count still zero means this is the lowest failing index
          if (fcnt_q == '0) begin
            ffi_d = idx_q;
          end
        end
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d    = idx_q + 1'b1;
          tmr_load = 1'b1;
          state_d  = SCAN_ST;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        mism_d  = (fcnt_q != '0);
        tmr_clr = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    vec_d = ((state_d == SETTLE) || (state_d == SAMPLE)) ? idx_d : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      exp_q   <= '0;
      tt_q    <= '0;
      fcnt_q  <= '0;
      ffi_q   <= '0;
      mism_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      exp_q   <= exp_d;
      tt_q    <= tt_d;
      fcnt_q  <= fcnt_d;
      ffi_q   <= ffi_d;
      mism_q  <= mism_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      vec_q   <= vec_d;
    end
  end

  assign bus.a_out          = vec_q[3];
  assign bus.b_out          = vec_q[2];
  assign bus.c_out          = vec_q[1];
  assign bus.d_out          = vec_q[0];
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.truth_table    = tt_q;
  assign bus.mismatch       = mism_q;
  assign bus.first_fail_idx = ffi_q;
  assign bus.fail_count     = fcnt_q;
endmodule

// File: tb/tb_tt_scanner.sv
// Bench for tt_scanner: a default build and a SETTLE_CYCLES=0 build beside a behavioural z=(a&b)|(c&d).
// A cycle-indexed scan model is checked every cycle; directed scans pin latencies and results.
module tb_tt_scanner;
  logic clk = 1'b0;
  logic rst_n;
  logic zero_mode;
  logic chk_en;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  tt_scanner_if if0 ();
  tt_scanner_if if1 ();

  assign if0.z_in = zero_mode ? 1'b0 : ((if0.a_out & if0.b_out) | (if0.c_out & if0.d_out));
  assign if1.z_in = zero_mode ? 1'b0 : ((if1.a_out & if1.b_out) | (if1.c_out & if1.d_out));

  tt_scanner #(.SETTLE_CYCLES(2)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  tt_scanner #(.SETTLE_CYCLES(0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  typedef struct packed {
    logic        busy;
    logic        done;
    logic [3:0]  vec;
    logic [15:0] tt;
    logic        mis;
    logic [3:0]  ffi;
    logic [4:0]  fc;
  } obs_t;

  function automatic obs_t observe(input int k);
    obs_t o;
    if (k == 0) begin
      o.busy = if0.busy; o.done = if0.done;
      o.vec  = {if0.a_out, if0.b_out, if0.c_out, if0.d_out};
      o.tt   = if0.truth_table; o.mis = if0.mismatch;
      o.ffi  = if0.first_fail_idx; o.fc = if0.fail_count;
    end else begin
      o.busy = if1.busy; o.done = if1.done;
      o.vec  = {if1.a_out, if1.b_out, if1.c_out, if1.d_out};
      o.tt   = if1.truth_table; o.mis = if1.mismatch;
      o.ffi  = if1.first_fail_idx; o.fc = if1.fail_count;
    end
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference truth table of the block wired to z_in, vector i = {a,b,c,d}
  function automatic logic [15:0] ztab(input logic zero);
    logic [15:0] t;
    t = '0;
    for (int i = 0; i < 16; i++) begin
      logic a, b, c, d;
      a = ((i >> 3) & 1) != 0; b = ((i >> 2) & 1) != 0;
      c = ((i >> 1) & 1) != 0; d = (i & 1) != 0;
      t[i] = zero ? 1'b0 : ((a & b) | (c & d));
    end
    return t;
  endfunction

  // Model: m = clock edges since the accepting start edge
  int          sc [2] = '{2, 0};
  bit          run [2];
  int          m [2];
  logic [15:0] mexp [2];
  logic [15:0] mtt [2];

  function automatic logic get_start(input int k);
    return (k == 0) ? if0.start : if1.start;
  endfunction

  function automatic logic [15:0] get_exp(input int k);
    return (k == 0) ? if0.expected : if1.expected;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int len;
      len = 16 * (sc[k] + 1);
      if (!rst_n) begin
        run[k] = 1'b0;
        m[k]   = 0;
      end else if (run[k] && m[k] <= len) begin
        m[k]++;
      end else if (get_start(k)) begin
        run[k]  = 1'b1;
        m[k]    = 0;
        mexp[k] = get_exp(k);
        mtt[k]  = ztab(zero_mode);
      end else if (run[k] && m[k] < 100000) begin
        m[k]++;
      end
    end
  end

  function automatic obs_t predict(input int k);
    obs_t e;
    int len, n, fc;
    logic [15:0] mask, fails;
    e = '0;
    if (run[k]) begin
      len = 16 * (sc[k] + 1);
      n = m[k] / (sc[k] + 1);
      if (n > 16) n = 16;
      mask = '0;
      for (int i = 0; i < n; i++) mask[i] = 1'b1;
      fails = (mtt[k] ^ mexp[k]) & mask;
      fc = 0;
      for (int i = 15; i >= 0; i--) begin
        if (fails[i]) begin
          fc++;
          e.ffi = 4'(i);
        end
      end
      e.fc   = 5'(fc);
      e.tt   = mtt[k] & mask;
      e.busy = (m[k] <= len);
      e.done = (m[k] == len + 1);
      e.vec  = (m[k] < len) ? 4'(m[k] / (sc[k] + 1)) : 4'd0;
      e.mis  = (m[k] >= len + 1) && (fc != 0);
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        obs_t a, e;
        a = observe(k);
        e = predict(k);
        chk($sformatf("dut%0d busy", k), 32'(a.busy), 32'(e.busy));
        chk($sformatf("dut%0d done", k), 32'(a.done), 32'(e.done));
        chk($sformatf("dut%0d vector", k), 32'(a.vec), 32'(e.vec));
        chk($sformatf("dut%0d truth_table", k), 32'(a.tt), 32'(e.tt));
        chk($sformatf("dut%0d mismatch", k), 32'(a.mis), 32'(e.mis));
        chk($sformatf("dut%0d first_fail_idx", k), 32'(a.ffi), 32'(e.ffi));
        chk($sformatf("dut%0d fail_count", k), 32'(a.fc), 32'(e.fc));
      end
    end
  end

  task automatic set_in(input int k, input logic s, input logic [15:0] e);
    if (k == 0) begin if0.start = s; if0.expected = e; end
    else begin if1.start = s; if1.expected = e; end
  endtask

  // Called at a negedge; returns at the negedge on which done is seen
  task automatic scan(input int k, input logic [15:0] e, output int lat);
    set_in(k, 1'b1, e);
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    set_in(k, 1'b0, e);
    while (!observe(k).done && lat < 300) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (lat >= 300) chk($sformatf("dut%0d done timeout", k), 32'(observe(k).done), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got running, want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t o;
    int   lat, lat2;
    bit   seen;

    chk_en = 1'b0;
    rst_n = 1'b0;
    zero_mode = 1'b0;
    set_in(0, 1'b0, 16'h0);
    set_in(1, 1'b0, 16'h0);
    repeat (2) @(negedge clk);
    o = observe(0);
    chk("reset busy", 32'(o.busy), 32'd0);
    chk("reset truth_table", 32'(o.tt), 32'd0);
    chk("reset fail_count", 32'(o.fc), 32'd0);
    chk_en = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);

    // 1: matching table
    scan(0, 16'hF888, lat);
    o = observe(0);
    chk("t1 latency", 32'(lat), 32'd49);
    chk("t1 truth_table", 32'(o.tt), 32'hF888);
    chk("t1 mismatch", 32'(o.mis), 32'd0);
    chk("t1 fail_count", 32'(o.fc), 32'd0);

    // 2: one wrong bit in expected
    scan(0, 16'hF880, lat);
    o = observe(0);
    chk("t2 mismatch", 32'(o.mis), 32'd1);
    chk("t2 first_fail_idx", 32'(o.ffi), 32'd3);
    chk("t2 fail_count", 32'(o.fc), 32'd1);
    chk("t2 truth_table", 32'(o.tt), 32'hF888);

    // 3: z stuck low against all-ones
    zero_mode = 1'b1;
    scan(0, 16'hFFFF, lat);
    o = observe(0);
    chk("t3 fail_count", 32'(o.fc), 32'd16);
    chk("t3 first_fail_idx", 32'(o.ffi), 32'd0);
    chk("t3 truth_table", 32'(o.tt), 32'd0);
    chk("t3 mismatch", 32'(o.mis), 32'd1);
    zero_mode = 1'b0;

    // 4: reset while vector 7 is driven
    set_in(0, 1'b1, 16'hF888);
    @(negedge clk);
    set_in(0, 1'b0, 16'hF888);
    lat = 0;
    while (observe(0).vec != 4'd7 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("t4 reached vector 7", 32'(observe(0).vec), 32'd7);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    o = observe(0);
    chk("t4 busy after reset", 32'(o.busy), 32'd0);
    chk("t4 vector after reset", 32'(o.vec), 32'd0);
    chk("t4 truth_table after reset", 32'(o.tt), 32'd0);
    chk("t4 fail_count after reset", 32'(o.fc), 32'd0);
    seen = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (observe(0).done) seen = 1'b1;
    end
    chk("t4 no done after reset", 32'(seen), 32'd0);
    scan(0, 16'hF888, lat);
    chk("t4 restart latency", 32'(lat), 32'd49);
    chk("t4 restart truth_table", 32'(observe(0).tt), 32'hF888);

    // 5: start held high; expected altered mid-scan
    set_in(0, 1'b1, 16'hF888);
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    while (!observe(0).done && lat < 300) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat == 10) set_in(0, 1'b1, 16'h0000);
    end
    o = observe(0);
    chk("t5 first latency", 32'(lat), 32'd49);
    chk("t5 first mismatch", 32'(o.mis), 32'd0);
    chk("t5 first truth_table", 32'(o.tt), 32'hF888);
    lat2 = 0;
    do begin
      @(posedge clk);
      lat2++;
      @(negedge clk);
    end while (!observe(0).done && lat2 < 300);
    set_in(0, 1'b0, 16'h0000);
    o = observe(0);
    chk("t5 done spacing", 32'(lat2), 32'd50);
    chk("t5 second mismatch", 32'(o.mis), 32'd1);
    chk("t5 second fail_count", 32'(o.fc), 32'd7);
    chk("t5 second first_fail_idx", 32'(o.ffi), 32'd3);

    // 6: zero-settle build
    scan(1, 16'hF888, lat);
    o = observe(1);
    chk("t6 latency", 32'(lat), 32'd17);
    chk("t6 truth_table", 32'(o.tt), 32'hF888);
    chk("t6 mismatch", 32'(o.mis), 32'd0);

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
